// File: rtl/pe_gather_buffer.sv
// Gather buffer behind one ring node's PE output port: FWFT FIFO with registered
// backpressure, per-VC arrival counters and a sticky gather-phase completion flag.
module pe_gather_buffer #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned EXPECT = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     peso,
  output logic                     pero,
  input  logic [DATA_W-1:0]        pedo,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [7:0]               vc0_cnt,
  output logic [7:0]               vc1_cnt,
  output logic                     gather_done,
  input  logic                     clear
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = 8;
  localparam int unsigned SW = CW + 1;

  typedef enum logic {
    COLLECT = 1'b0,
    DONE    = 1'b1
  } state_t;

  state_t            state;
  state_t            state_next;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wptr;
  logic [PW-1:0]     rptr;
  logic              overflow;

  logic              empty;
  logic              full;
  logic              push;
  logic              pop;
  logic [PW-1:0]     count;
  logic [PW-1:0]     count_next;
  logic              pero_next;
  logic [CW-1:0]     vc0_base;
  logic [CW-1:0]     vc1_base;
  logic [CW-1:0]     vc0_next;
  logic [CW-1:0]     vc1_next;
  logic [SW-1:0]     sum_next;
  logic              reached;

  // Pointer-derived status; a pop frees its slot before the same-cycle push lands.
  always_comb begin
    empty      = (wptr == rptr);
    full       = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    pop        = rd_en && !empty;
    push       = peso && (!full || pop);
    count      = wptr - rptr;
    count_next = count + PW'(push) - PW'(pop);
    pero_next  = (count_next <= PW'(DEPTH - 2));
  end

  // Clear applies first, then this cycle's accepted push increments its VC.
  always_comb begin
    vc0_base = clear ? '0 : vc0_cnt;
    vc1_base = clear ? '0 : vc1_cnt;
    vc0_next = vc0_base;
    vc1_next = vc1_base;
    if (push && !pedo[DATA_W-1] && (vc0_base != '1)) begin
      vc0_next = vc0_base + CW'(1);
    end
    if (push && pedo[DATA_W-1] && (vc1_base != '1)) begin
      vc1_next = vc1_base + CW'(1);
    end
    sum_next = SW'(vc0_next) + SW'(vc1_next);
    reached  = (sum_next >= SW'(EXPECT));
  end

  assign occupancy = count;
  assign rd_valid  = !empty;
  assign rd_data   = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem[wptr[AW-1:0]] <= pedo;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      pero     <= 1'b0;
      vc0_cnt  <= '0;
      vc1_cnt  <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wptr <= wptr + PW'(1);
      end
      if (pop) begin
        rptr <= rptr + PW'(1);
      end
      pero    <= pero_next;
      vc0_cnt <= vc0_next;
      vc1_cnt <= vc1_next;
      // Sticky debug flag: a push that found no free slot was lost.
      if (peso && !push) begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= COLLECT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      COLLECT: if (reached) state_next = DONE;
      DONE:    if (clear && !reached) state_next = COLLECT;
      default: state_next = COLLECT;
    endcase
  end

  assign gather_done = (state == DONE);

endmodule
